// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath for register-transfer testing.
// One shared bus links PC, IR, MAR, MDR, Y, Z-low, R3, R4 and R7.
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             MDRread,
    input  logic             MDRin,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             IRin,
    input  logic             RYin,
    input  logic             RZinLo,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R7in,
    input  logic             MDRout,
    input  logic             MARout,
    input  logic             PCout,
    input  logic             IRout,
    input  logic             RYout,
    input  logic             RZoutLo,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R7out,
    input  logic             IncPC,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] PCq,
    output logic [WIDTH-1:0] IRq,
    output logic [WIDTH-1:0] MARq,
    output logic [WIDTH-1:0] MDRq,
    output logic [WIDTH-1:0] Yq,
    output logic [WIDTH-1:0] ZLoq,
    output logic [WIDTH-1:0] R3q,
    output logic [WIDTH-1:0] R4q,
    output logic [WIDTH-1:0] R7q
);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, zlo_q;
    logic [WIDTH-1:0] r3_q, r4_q, r7_q;
    logic [WIDTH-1:0] pc_d, ir_d, mar_d, mdr_d, y_d, zlo_d;
    logic [WIDTH-1:0] r3_d, r4_d, r7_d;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] alu_res;
    logic [4:0]       opcode;

    assign opcode = ir_q[WIDTH-1 -: 5];

    // Bus mux: fixed priority, zero when nothing drives it
    always_comb begin
        bus = '0;
        if (MDRout)       bus = mdr_q;
        else if (RZoutLo) bus = zlo_q;
        else if (PCout)   bus = pc_q;
        else if (IRout)   bus = ir_q;
        else if (RYout)   bus = y_q;
        else if (MARout)  bus = mar_q;
        else if (R3out)   bus = r3_q;
        else if (R4out)   bus = r4_q;
        else if (R7out)   bus = r7_q;
    end

    // ALU: Y op bus, IncPC overrides the opcode with bus+1
    always_comb begin
        alu_res = y_q + bus;
        if (IncPC) begin
            alu_res = bus + 1'b1;
        end else begin
            case (opcode)
                OP_ADD:  alu_res = y_q + bus;
                OP_SUB:  alu_res = y_q - bus;
                OP_AND:  alu_res = y_q & bus;
                OP_OR:   alu_res = y_q | bus;
                OP_NEG:  alu_res = '0 - bus;
                OP_NOT:  alu_res = ~bus;
                default: alu_res = y_q + bus;
            endcase
        end
    end

    // Next-state: each register loads the bus when enabled, else holds
    always_comb begin
        pc_d  = PCin   ? bus : pc_q;
        ir_d  = IRin   ? bus : ir_q;
        mar_d = MARin  ? bus : mar_q;
        y_d   = RYin   ? bus : y_q;
        zlo_d = RZinLo ? alu_res : zlo_q;
        r3_d  = R3in   ? bus : r3_q;
        r4_d  = R4in   ? bus : r4_q;
        r7_d  = R7in   ? bus : r7_q;
        mdr_d = mdr_q;
        if (MDRin) mdr_d = MDRread ? Mdatain : bus;
    end

    // State registers with synchronous clear overriding all loads
    always_ff @(posedge clock) begin
        if (clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            zlo_q <= '0;
            r3_q  <= '0;
            r4_q  <= '0;
            r7_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            zlo_q <= zlo_d;
            r3_q  <= r3_d;
            r4_q  <= r4_d;
            r7_q  <= r7_d;
        end
    end

    assign BusMuxOut = bus;
    assign PCq       = pc_q;
    assign IRq       = ir_q;
    assign MARq      = mar_q;
    assign MDRq      = mdr_q;
    assign Yq        = y_q;
    assign ZLoq      = zlo_q;
    assign R3q       = r3_q;
    assign R4q       = r4_q;
    assign R7q       = r7_q;

endmodule

// File: tb/tb_datapath.sv
// Testbench for datapath: directed register transfers plus random
// control cycles checked against a behavioural register-file model.
module tb_datapath;

    // register indices used by the model and the control vectors
    localparam int PC = 0, IR = 1, MAR = 2, MDR = 3, Y = 4, Z = 5;
    localparam int R3 = 6, R4 = 7, R7 = 8;

    logic        clock = 1'b0;
    logic        clear, MDRread, IncPC;
    logic [31:0] Mdatain;
    logic [8:0]  ins, outs;
    logic [31:0] BusMuxOut, PCq, IRq, MARq, MDRq, Yq, ZLoq, R3q, R4q, R7q;

    int checks = 0;
    int errors = 0;

    logic [31:0] m [9];
    int prio [9] = '{MDR, Z, PC, IR, Y, MAR, R3, R4, R7};
    string names [9] = '{"PC", "IR", "MAR", "MDR", "Y", "ZLo", "R3", "R4", "R7"};

    always #5 clock = ~clock;

    datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .MDRread(MDRread),
        .MDRin(ins[MDR]), .MARin(ins[MAR]), .PCin(ins[PC]), .IRin(ins[IR]),
        .RYin(ins[Y]), .RZinLo(ins[Z]), .R3in(ins[R3]), .R4in(ins[R4]),
        .R7in(ins[R7]),
        .MDRout(outs[MDR]), .MARout(outs[MAR]), .PCout(outs[PC]),
        .IRout(outs[IR]), .RYout(outs[Y]), .RZoutLo(outs[Z]),
        .R3out(outs[R3]), .R4out(outs[R4]), .R7out(outs[R7]),
        .IncPC(IncPC), .BusMuxOut(BusMuxOut),
        .PCq(PCq), .IRq(IRq), .MARq(MARq), .MDRq(MDRq), .Yq(Yq),
        .ZLoq(ZLoq), .R3q(R3q), .R4q(R4q), .R7q(R7q)
    );

    function automatic logic [31:0] dut_reg(int i);
        case (i)
            PC:      return PCq;
            IR:      return IRq;
            MAR:     return MARq;
            MDR:     return MDRq;
            Y:       return Yq;
            Z:       return ZLoq;
            R3:      return R3q;
            R4:      return R4q;
            default: return R7q;
        endcase
    endfunction

    function automatic logic [31:0] model_bus();
        foreach (prio[k]) if (outs[prio[k]]) return m[prio[k]];
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_alu(logic [31:0] a, logic [31:0] b,
                                              logic [4:0] op, logic inc);
        if (inc) return b + 32'd1;
        case (op)
            5'd4:    return a - b;
            5'd5:    return a & b;
            5'd6:    return a | b;
            5'd17:   return 32'd0 - b;
            5'd18:   return ~b;
            default: return a + b;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one control step: drive, check bus, clock, advance model, check regs
    task automatic step(logic [8:0] o, logic [8:0] i, logic rd,
                        logic [31:0] md, logic inc, logic clr);
        logic [31:0] b;
        logic [31:0] nm [9];
        @(negedge clock);
        outs = o; ins = i; MDRread = rd; Mdatain = md;
        IncPC = inc; clear = clr;
        #1;
        b = model_bus();
        chk("bus", BusMuxOut, b);
        for (int k = 0; k < 9; k++) begin
            nm[k] = m[k];
            if (clr) nm[k] = 32'h0;
            else if (i[k]) begin
                if (k == MDR) nm[k] = rd ? md : b;
                else if (k == Z) nm[k] = model_alu(m[Y], b, m[IR][31:27], inc);
                else nm[k] = b;
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 9; k++) begin
            m[k] = nm[k];
            chk(names[k], dut_reg(k), m[k]);
        end
    endtask

    function automatic logic [8:0] bit9(int k);
        logic [8:0] v;
        v = 9'b0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [4:0]  ops [8] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd17, 5'd18, 5'd0, 5'd31};
        logic [8:0]  o, i;
        logic [31:0] md;
        outs = '0; ins = '0; MDRread = 0; Mdatain = '0; IncPC = 0; clear = 1;
        foreach (m[k]) m[k] = 32'hx;

        // reset from unknown state
        step(9'b0, 9'b0, 0, 0, 0, 1);
        // arbitrary loads then clear
        step(9'b0, bit9(MDR), 1, 32'hDEAD_BEEF, 0, 0);
        step(bit9(MDR), 9'h1FF & ~bit9(MDR), 0, 0, 0, 0);
        step(9'b0, 9'b0, 0, 0, 0, 1);
        chk("reset_R7", R7q, 32'h0);

        // register loads
        step(9'b0, bit9(MDR), 1, 32'h22, 0, 0);
        step(bit9(MDR), bit9(R3), 0, 0, 0, 0);
        step(9'b0, bit9(MDR), 1, 32'h24, 0, 0);
        step(bit9(MDR), bit9(R7), 0, 0, 0, 0);
        step(9'b0, bit9(MDR), 1, 32'h28, 0, 0);
        step(bit9(MDR), bit9(R4), 0, 0, 0, 0);
        chk("load_R3", R3q, 32'h22);
        chk("load_R7", R7q, 32'h24);
        chk("load_R4", R4q, 32'h28);

        // fetch: T0..T2
        step(bit9(PC), bit9(MAR) | bit9(Z), 0, 0, 1, 0);
        chk("fetch_MAR", MARq, 32'h0);
        chk("fetch_Z", ZLoq, 32'h1);
        step(9'b0, bit9(MDR), 1, 32'h222B_8000, 0, 0);
        step(bit9(MDR), bit9(IR), 0, 0, 0, 0);
        chk("fetch_IR", IRq, 32'h222B_8000);

        // subtract T3..T5
        step(bit9(R3), bit9(Y), 0, 0, 0, 0);
        step(bit9(R7), bit9(Z), 0, 0, 0, 0);
        step(bit9(Z), bit9(R4), 0, 0, 0, 0);
        chk("sub_R4", R4q, 32'hFFFF_FFFE);

        // add with IR=0x18000000
        step(9'b0, bit9(MDR), 1, 32'h1800_0000, 0, 0);
        step(bit9(MDR), bit9(IR), 0, 0, 0, 0);
        step(bit9(R3), bit9(Y), 0, 0, 0, 0);
        step(bit9(R7), bit9(Z), 0, 0, 0, 0);
        step(bit9(Z), bit9(R4), 0, 0, 0, 0);
        chk("add_R4", R4q, 32'h46);

        // idle bus and priority
        step(9'b0, 9'b0, 0, 0, 0, 0);
        chk("bus_idle", BusMuxOut, 32'h0);
        step(bit9(MDR) | bit9(R3), bit9(R7), 0, 0, 0, 0);
        chk("bus_prio_R7", R7q, 32'h1800_0000);

        // same register in and out: no change
        step(bit9(R4), bit9(R4), 0, 0, 0, 0);
        chk("self_R4", R4q, 32'h46);

        // random control cycles
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 11));
            o = (sel < 9) ? bit9(sel) : 9'b0;
            if (sel == 10) o = 9'($urandom);
            i = 9'($urandom) & 9'($urandom);
            md = $urandom;
            if ($urandom_range(0, 1) == 1)
                md[31:27] = ops[$urandom_range(0, 7)];
            step(o, i, 1'($urandom), md, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 40) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
